// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared word/address sizes and RV32I load/store funct3 codes.
package dmem_responder_pkg;
   localparam int WORD_LEN  = 32;
   localparam int ADDR_SIZE = 32;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane mask, store replication, load extraction/extension,
// misalignment and illegal-funct3 detection for one access.
module dmem_lane_align
   import dmem_responder_pkg::*;
(
   input  logic                i_write,
   input  logic [2:0]          i_funct3,
   input  logic [1:0]          i_off,
   input  logic [WORD_LEN-1:0] i_wdata,
   input  logic [WORD_LEN-1:0] i_rword,
   output logic [3:0]          o_be,
   output logic [WORD_LEN-1:0] o_wdata,
   output logic [WORD_LEN-1:0] o_rdata,
   output logic                o_misalign,
   output logic                o_bad_f3
);
   logic [WORD_LEN-1:0] w_sh;
   logic [1:0]          w_sz;
   always_comb begin
      w_sz       = i_funct3[1:0];
      w_sh       = i_rword >> {i_off, 3'b000};
      o_bad_f3   = i_write ? !(i_funct3 inside {F3_SB, F3_SH, F3_SW})
                           : !(i_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      o_misalign = (w_sz == 2'b01 && i_off[0]) || (w_sz == 2'b10 && i_off != 2'b00);
      o_be       = w_sz == 2'b00 ? 4'b0001 << i_off :
                   w_sz == 2'b01 ? (i_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      o_wdata    = w_sz == 2'b00 ? {4{i_wdata[7:0]}} :
                   w_sz == 2'b01 ? {2{i_wdata[15:0]}} : i_wdata;
      o_rdata    = i_funct3 == F3_LB  ? {{24{w_sh[7]}}, w_sh[7:0]} :
                   i_funct3 == F3_LH  ? {{16{w_sh[15]}}, w_sh[15:0]} :
                   i_funct3 == F3_LBU ? {24'h0, w_sh[7:0]} :
                   i_funct3 == F3_LHU ? {16'h0, w_sh[15:0]} : w_sh;
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory with programmable wait-states,
// RV32I byte/half/word access and error responses for illegal requests.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_SIZE-1:0] req_addr,
   input  logic [2:0]           req_funct3,
   input  logic [WORD_LEN-1:0]  req_wdata,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [WORD_LEN-1:0]  resp_rdata,
   output logic                 resp_err
);
   localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t              r_state;
   logic [3:0]          r_cnt;
   logic                r_write;
   logic [AW+1:0]       r_addr;
   logic [2:0]          r_f3;
   logic [WORD_LEN-1:0] r_wdata;
   logic [WORD_LEN-1:0] r_rdata;
   logic                r_err;
   logic [WORD_LEN-1:0] r_mem [DEPTH_WORDS];
   logic                w_idle;
   logic                w_exec;
   logic                w_oor;
   logic                w_req_err;
   logic [3:0]          w_be;
   logic [WORD_LEN-1:0] w_wdata;
   logic [WORD_LEN-1:0] w_rdata;
   logic                w_misalign;
   logic                w_bad_f3;
   assign w_idle     = r_state == IDLE;
   assign w_exec     = r_state == WAIT && r_cnt == 4'd0;
   assign w_oor      = {2'b00, req_addr[ADDR_SIZE-1:2]} >= ADDR_SIZE'(DEPTH_WORDS);
   assign w_req_err  = w_bad_f3 | w_misalign | w_oor;
   assign req_ready  = w_idle;
   assign resp_valid = r_state == RESP;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;
   // In IDLE the aligner checks the incoming request; afterwards it serves the captured one.
   dmem_lane_align u_align (
      .i_write    (w_idle ? req_write : r_write),
      .i_funct3   (w_idle ? req_funct3 : r_f3),
      .i_off      (w_idle ? req_addr[1:0] : r_addr[1:0]),
      .i_wdata    (r_wdata),
      .i_rword    (r_mem[r_addr[AW+1:2]]),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_rdata    (w_rdata),
      .o_misalign (w_misalign),
      .o_bad_f3   (w_bad_f3)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_write <= req_write;
               r_addr  <= req_addr[AW+1:0];
               r_f3    <= req_funct3;
               r_wdata <= req_wdata;
               r_err   <= w_req_err;
               r_rdata <= '0;
               r_cnt   <= 4'(WAIT_CYCLES);
               r_state <= w_req_err ? RESP : WAIT;
            end
            WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                  else begin
                     r_rdata <= r_write ? '0 : w_rdata;
                     r_state <= RESP;
                  end
            RESP: if (resp_ready) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
   // Storage is never reset; a reset edge suppresses a store that would commit on it.
   always_ff @(posedge clk) begin
      if (rst && w_exec && r_write)
         for (int i = 0; i < 4; i++)
            if (w_be[i]) r_mem[r_addr[AW+1:2]][8*i+:8] <= w_wdata[8*i+:8];
   end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (DEPTH 1024, 2 wait-states).
module tb_dmem_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   int          n_chk = 0;
   int          n_fail = 0;
   logic [31:0] rd;
   logic        er;
   int          lat;
   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic wait_resp(output int l);
      l = 0;
      while (!resp_valid && l < 20) begin
         @(posedge clk);
         #1;
         l++;
      end
   endtask
   task automatic do_req(input logic w, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] r, output logic e, output int l);
      @(negedge clk);
      req_write = w; req_addr = a; req_funct3 = f3; req_wdata = wd; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_resp(l);
      r = resp_rdata;
      e = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      rst = 1'b1;
      do_req(1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
      chk("sw_err", 32'(er), 32'd0);
      chk("sw_rdata", rd, 32'h0);
      chk("sw_lat", 32'(lat), 32'd3);
      do_req(0, 32'h10, 3'b010, 32'h0, rd, er, lat);
      chk("lw_rdata", rd, 32'hDEADBEEF);
      chk("lw_err", 32'(er), 32'd0);
      chk("lw_lat", 32'(lat), 32'd3);
      do_req(1, 32'h13, 3'b000, 32'h00000080, rd, er, lat);
      chk("sb_err", 32'(er), 32'd0);
      do_req(0, 32'h13, 3'b000, 32'h0, rd, er, lat);
      chk("lb_13", rd, 32'hFFFFFF80);
      do_req(0, 32'h13, 3'b100, 32'h0, rd, er, lat);
      chk("lbu_13", rd, 32'h00000080);
      do_req(0, 32'h10, 3'b010, 32'h0, rd, er, lat);
      chk("lw_after_sb", rd, 32'h80ADBEEF);
      do_req(0, 32'h11, 3'b001, 32'h0, rd, er, lat);
      chk("lh_mis_err", 32'(er), 32'd1);
      chk("lh_mis_rdata", rd, 32'h0);
      chk("lh_mis_lat", 32'(lat), 32'd0);
      do_req(1, 32'h12, 3'b010, 32'h11111111, rd, er, lat);
      chk("sw_mis_err", 32'(er), 32'd1);
      chk("sw_mis_rdata", rd, 32'h0);
      chk("sw_mis_lat", 32'(lat), 32'd0);
      do_req(0, 32'h10, 3'b010, 32'h0, rd, er, lat);
      chk("lw_no_change", rd, 32'h80ADBEEF);
      do_req(0, 32'h10, 3'b011, 32'h0, rd, er, lat);
      chk("f3_011_err", 32'(er), 32'd1);
      do_req(1, 32'h10, 3'b100, 32'h0, rd, er, lat);
      chk("store_f3_100_err", 32'(er), 32'd1);
      do_req(0, 32'd4096, 3'b010, 32'h0, rd, er, lat);
      chk("oor_err", 32'(er), 32'd1);
      chk("oor_rdata", rd, 32'h0);
      do_req(0, 32'd4092, 3'b010, 32'h0, rd, er, lat);
      chk("last_word_err", 32'(er), 32'd0);
      do_req(0, 32'h10, 3'b010, 32'h0, rd, er, lat);
      chk("lw_after_errs", rd, 32'h80ADBEEF);
      do_req(0, 32'h12, 3'b001, 32'h0, rd, er, lat);
      chk("lh_12", rd, 32'hFFFF80AD);
      do_req(0, 32'h10, 3'b101, 32'h0, rd, er, lat);
      chk("lhu_10", rd, 32'h0000BEEF);
      do_req(1, 32'h12, 3'b001, 32'hFFFF1234, rd, er, lat);
      chk("sh_err", 32'(er), 32'd0);
      do_req(0, 32'h10, 3'b010, 32'h0, rd, er, lat);
      chk("lw_after_sh", rd, 32'h1234BEEF);
      do_req(0, 32'h10, 3'b000, 32'h0, rd, er, lat);
      chk("lb_10", rd, 32'hFFFFFFEF);
      do_req(0, 32'h11, 3'b000, 32'h0, rd, er, lat);
      chk("lb_11", rd, 32'hFFFFFFBE);
      // Backpressure: stall the response while a store is presented on the inputs.
      @(negedge clk);
      req_write = 1'b0; req_addr = 32'h10; req_funct3 = 3'b010; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      wait_resp(lat);
      chk("hold_lat", 32'(lat), 32'd3);
      chk("hold_rdata0", resp_rdata, 32'h1234BEEF);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("hold_valid", 32'(resp_valid), 32'd1);
         chk("hold_rdata", resp_rdata, 32'h1234BEEF);
         chk("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      req_valid = 1'b0;
      chk("post_hs_req_ready", 32'(req_ready), 32'd1);
      chk("post_hs_resp_valid", 32'(resp_valid), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("no_stray_accept", 32'(resp_valid), 32'd0);
      do_req(0, 32'h10, 3'b010, 32'h0, rd, er, lat);
      chk("lw_after_hold", rd, 32'h1234BEEF);
      // Reset during WAIT must drop the pending store.
      do_req(1, 32'h20, 3'b010, 32'hCAFEF00D, rd, er, lat);
      chk("sw20_err", 32'(er), 32'd0);
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h20; req_funct3 = 3'b010; req_wdata = 32'h12345678; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      chk("wait_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_resp_err", 32'(resp_err), 32'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("abort_stays_idle", 32'(resp_valid), 32'd0);
      do_req(0, 32'h20, 3'b010, 32'h0, rd, er, lat);
      chk("lw_after_abort", rd, 32'hCAFEF00D);
      chk("lw_after_abort_err", 32'(er), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
